// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
    parameter int DATA_W = 70,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam logic [1:0] EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2;
    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] main_q, skid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              push, pop;
    // state register; encoding doubles as the occupancy count
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end
    // next state from handshake, flush overrides everything
    always_comb begin
        push = up_valid_i & up_ready_o;
        pop  = dn_valid_o & dn_ready_i;
        state_nxt = flush_i          ? EMPTY :
                    (state == EMPTY) ? (push ? HALF : EMPTY) :
                    (state == HALF)  ? ((push & !pop) ? FULL : (!push & pop) ? EMPTY : HALF) :
                                       (pop ? HALF : FULL);
    end
    // outputs depend only on the state register, so no input-to-output comb path
    always_comb begin
        up_ready_o  = state != FULL;
        dn_valid_o  = state != EMPTY;
        occupancy_o = state;
    end
    // payload storage: main feeds downstream, skid absorbs the one in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush_i) begin
            if (push && (state == EMPTY || pop)) main_q <= up_data_i;
            else if (push)                       skid_q <= up_data_i;
            else if (state == FULL && pop)       main_q <= skid_q;
        end
    end
    // saturating count of cycles where downstream withholds ready
    always_ff @(posedge clk) begin
        if (rst)                                   cnt_q <= '0;
        else if (dn_valid_o && !dn_ready_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign dn_data_o   = main_q;
    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
    localparam int DW = 16;
    localparam int CW = 4;
    logic          clk = 0;
    logic          rst = 1;
    logic          flush = 0;
    logic          up_valid = 0;
    logic [DW-1:0] up_data = '0;
    logic          up_ready;
    logic          dn_valid;
    logic [DW-1:0] dn_data;
    logic          dn_ready = 0;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] q[$];
    int            m_cnt = 0;

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .up_valid_i(up_valid), .up_data_i(up_data), .up_ready_o(up_ready),
        .dn_valid_o(dn_valid), .dn_data_o(dn_data), .dn_ready_i(dn_ready),
        .occupancy_o(occupancy), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // compare every DUT output against the model queue
    task automatic check_all();
        chk("up_ready", 32'(up_ready), 32'(q.size() < 2));
        chk("dn_valid", 32'(dn_valid), 32'(q.size() > 0));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (q.size() > 0) chk("dn_data", 32'(dn_data), 32'(q[0]));
    endtask

    // advance one clock, update the model from the pre-edge inputs, then check
    task automatic step();
        bit push, pop, stall;
        logic [DW-1:0] d;
        push  = up_valid && q.size() < 2;
        pop   = q.size() > 0 && dn_ready;
        stall = q.size() > 0 && !dn_ready;
        d     = up_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (stall && m_cnt < (1 << CW) - 1) m_cnt++;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        step();
        chk("reset_dn_data", 32'(dn_data), 32'h0);
        rst = 0;
        // streaming at full rate
        dn_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            up_valid = 1;
            up_data = DW'(i);
            step();
            chk("stream_data", 32'(dn_data), 32'(i));
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        up_valid = 0;
        step();
        // back-pressure: A, B fill the stage, C must wait upstream
        dn_ready = 0;
        up_valid = 1; up_data = 'hA; step();
        up_data = 'hB; step();
        chk("bp_full", 32'(occupancy), 32'd2);
        up_data = 'hC; step();
        chk("bp_ready_low", 32'(up_ready), 32'd0);
        dn_ready = 1;
        step();
        chk("bp_first", 32'(dn_data), 32'hB);
        chk("bp_ready_back", 32'(up_ready), 32'd1);
        step();
        chk("bp_third", 32'(dn_data), 32'hC);
        up_valid = 0;
        step();
        // stall counter saturation
        up_valid = 1; up_data = 'h55; dn_ready = 0; step();
        up_valid = 0;
        for (int i = 0; i < 20; i++) step();
        chk("sat", 32'(stall_cnt), 32'hF);
        // flush in FULL with a simultaneous push
        up_valid = 1; up_data = 'h66; step();
        chk("pre_flush_full", 32'(occupancy), 32'd2);
        flush = 1; up_data = 'hEE; step();
        flush = 0; up_valid = 0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_ready", 32'(up_ready), 32'd1);
        dn_ready = 1;
        up_valid = 1; up_data = 'h77; step();
        chk("post_flush", 32'(dn_data), 32'h77);
        up_valid = 0; step();
        // reset mid-stream in FULL with stall count 7
        rst = 1; step(); rst = 0;
        dn_ready = 0;
        up_valid = 1; up_data = 'h11; step();
        up_data = 'h22; step();
        up_valid = 0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_cnt", 32'(stall_cnt), 32'd7);
        rst = 1; step(); rst = 0;
        chk("rst_dn_data", 32'(dn_data), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        up_valid = 1; up_data = 'h3C; step();
        chk("post_rst_push", 32'(dn_data), 32'h3C);
        up_valid = 0; dn_ready = 1; step();
        // random traffic
        for (int i = 0; i < 1000; i++) begin
            up_valid = 1'($urandom);
            up_data = DW'($urandom);
            dn_ready = 1'($urandom);
            flush = ($urandom_range(0, 49) == 0);
            step();
            chk("occ_bound", 32'(occupancy <= 2), 32'd1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that replaces the fixed, always-advancing inter-stage registers with a valid/ready handshake and a 2-entry skid buffer. It carries an opaque payload of DATA_W bits, such as the packed MEM→WB bundle {pc, rf_we, wr, wd}, so downstream stalls back-pressure upstream without a combinational ready path. It also supports synchronous flush for squashing in-flight instructions and counts downstream stall cycles for performance analysis. It sits between any two pipeline stages of the core.

## Interface
Parameters:
- DATA_W, default 70: payload width in bits (70 = 32 pc + 1 rf_we + 5 wr + 32 wd).
- CNT_W, default 16: stall-counter width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- flush_i  input  1  squash all held entries (synchronous).
- up_valid_i  input  1  upstream presents a payload.
- up_data_i  input  DATA_W  upstream payload.
- up_ready_o  output  1  stage can accept; registered.
- dn_valid_o  output  1  downstream payload valid; registered.
- dn_data_o  output  DATA_W  downstream payload; registered.
- dn_ready_i  input  1  downstream accepts.
- occupancy_o  output  2  entries held: 0, 1 or 2.
- stall_cnt_o  output  CNT_W  saturating count of downstream-stall cycles.

## Operation
- Storage consists of a main register (drives dn_data_o) and a skid register, plus valid bits.
- push = up_valid_i & up_ready_o. pop = dn_valid_o & dn_ready_i.
- States are EMPTY (occ 0), HALF (main valid, occ 1) and FULL (main and skid valid, occ 2).
- EMPTY:
  - push → HALF, main <= up_data_i.
  - No push → stay in EMPTY.
- HALF:
  - push & pop → HALF, main <= up_data_i.
  - push & !pop → FULL, skid <= up_data_i.
  - !push & pop → EMPTY.
  - Otherwise → hold.
- FULL:
  - up_ready_o = 0, so no push can occur.
  - pop → HALF, main <= skid.
  - Otherwise → hold.
- Derived outputs:
  - up_ready_o = (state != FULL).
  - dn_valid_o = (state != EMPTY).
  - occupancy_o encodes the state.
- Payload ordering is strictly FIFO. No entry is duplicated or lost except by flush.
- Flush:
  - flush_i forces EMPTY and clears both valid bits.
  - A push in the same cycle is discarded.
  - A pop in the same cycle is still considered taken by downstream.
  - Data registers may keep stale contents; consumers must qualify with dn_valid_o.
- Stall counter:
  - Increments by 1 each cycle where dn_valid_o & !dn_ready_i.
  - Saturates at all-ones; never wraps.
  - Unaffected by flush_i; cleared only by rst.
- Priority order: rst > flush_i > handshake.

## Timing
- Reset values: up_ready_o = 1, dn_valid_o = 0, dn_data_o = 0, occupancy_o = 0, stall_cnt_o = 0. The skid register is also reset to 0.
- Latency: a payload pushed at edge N is visible on dn_data_o/dn_valid_o after edge N (one cycle).
- Throughput: one payload per cycle while dn_ready_i stays high.
- No combinational paths:
  - up_valid_i → dn_valid_o
  - dn_ready_i → up_ready_o
  - up_data_i → dn_data_o
- Back-pressure:
  - After dn_ready_i drops, at most one more payload is accepted (into skid) before up_ready_o falls.
  - up_ready_o rises again the cycle after the first pop from FULL.
- Assertion mid-operation:
  - rst asserted in any state → reset values after the next edge.
  - flush_i asserted in any state → EMPTY after the next edge, with up_ready_o = 1.

## Test plan
- Streaming: dn_ready_i = 1, push 0x01..0x05 on consecutive cycles → dn_data_o shows 0x01..0x05 one cycle later, occupancy_o stays 1, stall_cnt_o = 0.
- Back-pressure: push 0xA, 0xB with dn_ready_i = 0 → occupancy 2, up_ready_o = 0, 0xC held upstream. Raise dn_ready_i → outputs in order 0xA, 0xB, 0xC; up_ready_o returns to 1 one cycle after the first pop.
- Stall counter saturation: with CNT_W = 4, hold dn_valid_o = 1 and dn_ready_i = 0 for 20 cycles → stall_cnt_o = 15, no wrap.
- Flush in FULL with a simultaneous up_valid_i: next cycle occupancy 0, dn_valid_o = 0, up_ready_o = 1, and the flushed-cycle payload never appears.
- Reset mid-stream: assert rst in state FULL with stall_cnt_o = 7 → next cycle all outputs at reset values. A subsequent push of 0x3C appears one cycle later.
- Random valid/ready: 1000 cycles with a scoreboard → output sequence equals input sequence, occupancy_o never exceeds 2, no push while up_ready_o = 0.
